// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the EX operand source selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_STALL  = 2'd1,
    MULDIV_BUSY = 2'd2,
    FLUSH       = 2'd3
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Register-match comparator for one operand: the near (younger) producer wins
// over the far one, and register 0 never matches.
module forward_unit (
  input  logic [4:0] srcReg,
  input  logic [4:0] nearRd,
  input  logic       nearWrite,
  input  logic [4:0] farRd,
  input  logic       farWrite,
  output logic [1:0] fwdSel
);
  import hazard_pkg::*;

  logic nearHit;
  logic farHit;

  assign nearHit = nearWrite && (nearRd != 5'd0) && (nearRd == srcReg);
  assign farHit  = farWrite && (farRd != 5'd0) && (farRd == srcReg);
  assign fwdSel  = nearHit ? FWD_MEM : (farHit ? FWD_WB : FWD_REG);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control for a 5-stage pipeline. Define HAZ_FORWARD_EN to
// enable MEM/WB bypassing; otherwise decode stalls on any register dependency.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRt,
  input  logic        IDJump,
  input  logic [4:0]  EXRd,
  input  logic        EXRegWrite,
  input  logic        EXMemRead,
  input  logic        EXJr,
  input  logic        EXMulDiv,
  input  logic [4:0]  MEMRd,
  input  logic        MEMRegWrite,
  input  logic        MEMBranchTaken,
  output logic        PCWrite,
  output logic        FDWrite,
  output logic        FDFlush,
  output logic        DEFlush,
  output logic        EMFlush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic [31:0] StallCount
);
  import hazard_pkg::*;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

  state_t     state;
  state_t     stateNext;
  logic [3:0] mdCount;
  logic [3:0] mdCountNext;
  logic [1:0] selA;
  logic [1:0] selB;
  logic       loadUse;
  logic       dataHazard;

  assign loadUse = EXMemRead && (EXRd != 5'd0) &&
                   ((EXRd == IDRs) || (IDUsesRt && (EXRd == IDRt)));

`ifdef HAZ_FORWARD_EN
  logic [4:0] exRs;
  logic [4:0] exRt;
  logic [4:0] wbRd;
  logic       wbWrite;

  forward_unit fwdA (.srcReg(exRs), .nearRd(MEMRd), .nearWrite(MEMRegWrite),
                     .farRd(wbRd), .farWrite(wbWrite), .fwdSel(selA));
  forward_unit fwdB (.srcReg(exRt), .nearRd(MEMRd), .nearWrite(MEMRegWrite),
                     .farRd(wbRd), .farWrite(wbWrite), .fwdSel(selB));

  assign dataHazard = 1'b0;
  assign ForwardA   = Reset ? FWD_REG : selA;
  assign ForwardB   = Reset ? FWD_REG : selB;

  // Shadow the EX-stage sources and the WB destination; EMFlush without
  // DEFlush only happens while a mul/div holds EX, so the sources hold too.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      exRs    <= 5'd0;
      exRt    <= 5'd0;
      wbRd    <= 5'd0;
      wbWrite <= 1'b0;
    end else begin
      wbRd    <= MEMRd;
      wbWrite <= MEMRegWrite;
      if (DEFlush) begin
        exRs <= 5'd0;
        exRt <= 5'd0;
      end else if (!EMFlush) begin
        exRs <= IDRs;
        exRt <= IDRt;
      end
    end
  end
`else
  // No bypass network: the comparators watch the decode sources against the
  // EX (far) and MEM (near) destinations and any hit holds decode.
  forward_unit fwdA (.srcReg(IDRs), .nearRd(MEMRd), .nearWrite(MEMRegWrite),
                     .farRd(EXRd), .farWrite(EXRegWrite), .fwdSel(selA));
  forward_unit fwdB (.srcReg(IDRt), .nearRd(MEMRd), .nearWrite(MEMRegWrite),
                     .farRd(EXRd), .farWrite(EXRegWrite), .fwdSel(selB));

  assign dataHazard = (selA != FWD_REG) || (IDUsesRt && (selB != FWD_REG));
  assign ForwardA   = FWD_REG;
  assign ForwardB   = FWD_REG;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RUN;
      mdCount    <= 4'd0;
      StallCount <= 32'd0;
    end else begin
      state   <= stateNext;
      mdCount <= mdCountNext;
      if (!PCWrite) StallCount <= StallCount + 32'd1;
    end
  end

  // Event priority: branch, pending flush, jr, jump, mul/div, then data hazards.
  always_comb begin
    stateNext   = state;
    mdCountNext = mdCount;
    PCWrite     = 1'b1;
    FDWrite     = 1'b1;
    FDFlush     = 1'b0;
    DEFlush     = 1'b0;
    EMFlush     = 1'b0;
    if (Reset) begin
      PCWrite     = 1'b0;
      FDWrite     = 1'b0;
      FDFlush     = 1'b1;
      DEFlush     = 1'b1;
      EMFlush     = 1'b1;
      stateNext   = RUN;
      mdCountNext = 4'd0;
    end else if (MEMBranchTaken) begin
      FDFlush     = 1'b1;
      DEFlush     = 1'b1;
      EMFlush     = 1'b1;
      stateNext   = FLUSH;
      mdCountNext = 4'd0;
    end else if (state == FLUSH) begin
      FDFlush   = 1'b1;
      stateNext = RUN;
    end else if (EXJr) begin
      FDFlush = 1'b1;
      DEFlush = 1'b1;
    end else if (IDJump) begin
      FDFlush = 1'b1;
    end else if (state == MULDIV_BUSY) begin
      PCWrite     = 1'b0;
      FDWrite     = 1'b0;
      EMFlush     = 1'b1;
      mdCountNext = mdCount - 4'd1;
      if (mdCount <= 4'd1) begin
        stateNext   = RUN;
        mdCountNext = 4'd0;
      end
    end else if (EXMulDiv) begin
      PCWrite     = 1'b0;
      FDWrite     = 1'b0;
      EMFlush     = 1'b1;
      stateNext   = MULDIV_BUSY;
      mdCountNext = MD_LOAD;
    end else if (loadUse || dataHazard) begin
      PCWrite   = 1'b0;
      FDWrite   = 1'b0;
      DEFlush   = 1'b1;
      stateNext = LOAD_STALL;
    end else begin
      stateNext = RUN;
    end
  end

endmodule
